// File: rtl/execute_memory_pipe.sv
// Execute + data-memory pipe: ALU in E, byte-addressed memory in M, registered W.
// Optional macro EXMEM_MISALIGN_TRAP_EN suppresses misaligned accesses.
module execute_memory_pipe #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 256,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   WriteData,
  input  logic [XLEN-1:0]   ImmExt,
  input  logic [2:0]        ALUControl,
  input  logic              ALUSrc,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic [REG_AW-1:0] RdIn,
  input  logic              RegWriteIn,
  output logic              zero_E,
  output logic [XLEN-1:0]   ALUResult_M,
  output logic [REG_AW-1:0] Rd_M,
  output logic              RegWrite_M,
  output logic              out_valid,
  output logic [XLEN-1:0]   Result_W,
  output logic [REG_AW-1:0] Rd_W,
  output logic              RegWrite_W,
  output logic              misalign_W
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(XLEN);
`ifdef EXMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic [XLEN-1:0]   b_e, alu_e;
  logic              valid_m_q, we_m_q, re_m_q, uns_m_q, rw_m_q;
  logic [XLEN-1:0]   alu_m_q, wd_m_q;
  logic [1:0]        size_m_q;
  logic [REG_AW-1:0] rd_m_q;
  logic              valid_w_q, rw_w_q, mis_w_q;
  logic [XLEN-1:0]   res_w_q;
  logic [REG_AW-1:0] rd_w_q;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic [1:0]        sz_m;
  int                nbi, offi, aoi;
  logic              acc_m, mis_m, is_load_m, store_en;
  logic [AW-1:0]     idx_m;
  logic [NB-1:0]     bem_m;
  logic [XLEN-1:0]   rep_m, rword, sh_m, mask_m, top_m, ext_m, ld_m;

  // E stage: operand select and ALU
  always_comb begin
    b_e   = ALUSrc ? ImmExt : WriteData;
    alu_e = '0;
    unique case (ALUControl)
      3'b000: alu_e = SrcA + b_e;
      3'b001: alu_e = SrcA - b_e;
      3'b010: alu_e = SrcA & b_e;
      3'b011: alu_e = SrcA | b_e;
      3'b100: alu_e = SrcA ^ b_e;
      3'b101: alu_e = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(b_e)};
      3'b110: alu_e = SrcA << b_e[SW-1:0];
      3'b111: alu_e = SrcA >> b_e[SW-1:0];
    endcase
  end

  assign zero_E = (alu_e == '0);

  // E->M register; a flush loads a bubble even while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m_q <= 1'b0;
      alu_m_q   <= '0;
      wd_m_q    <= '0;
      we_m_q    <= 1'b0;
      re_m_q    <= 1'b0;
      size_m_q  <= 2'b00;
      uns_m_q   <= 1'b0;
      rd_m_q    <= '0;
      rw_m_q    <= 1'b0;
    end else if (flush || !stall) begin
      valid_m_q <= in_valid & ~flush;
      alu_m_q   <= alu_e;
      wd_m_q    <= WriteData;
      we_m_q    <= MemWrite;
      re_m_q    <= MemRead;
      size_m_q  <= MemSize;
      uns_m_q   <= MemUnsigned;
      rd_m_q    <= RdIn;
      rw_m_q    <= RegWriteIn;
    end
  end

  // M stage: lane selection, store data replication, load extraction
  always_comb begin
    sz_m = (XLEN == 32 && size_m_q == 2'b11) ? 2'b10 : size_m_q;
    nbi  = 1 << sz_m;
    offi = int'(alu_m_q[OB-1:0]);
    aoi  = offi & ~(nbi - 1);
    acc_m = we_m_q | re_m_q;
    mis_m = acc_m && ((offi & (nbi - 1)) != 0);
    is_load_m = re_m_q & ~we_m_q;
    idx_m = alu_m_q[AW+OB-1:OB];
    bem_m = NB'(((1 << nbi) - 1) << aoi);
    rep_m = wd_m_q;
    unique case (sz_m)
      2'b00: rep_m = {NB{wd_m_q[7:0]}};
      2'b01: rep_m = {(NB/2){wd_m_q[15:0]}};
      2'b10: rep_m = {(NB/4){wd_m_q[31:0]}};
      2'b11: rep_m = wd_m_q;
    endcase
    rword = mem_q[idx_m];
    sh_m  = rword >> (8 * aoi);
    if (8 * nbi >= XLEN) mask_m = '1;
    else mask_m = (XLEN'(1) << (8 * nbi)) - XLEN'(1);
    top_m = mask_m & ~(mask_m >> 1);
    ext_m = sh_m & mask_m;
    if (!uns_m_q && |(sh_m & top_m)) ext_m = ext_m | ~mask_m;
    ld_m = (TRAP && mis_m) ? '0 : ext_m;
    store_en = valid_m_q & we_m_q & ~stall & ~reset & ~(TRAP & mis_m);
  end

  // Data memory byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (store_en && bem_m[i]) mem_q[idx_m][8*i +: 8] <= rep_m[8*i +: 8];
    end
  end

  // M->W register; holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_w_q <= 1'b0;
      res_w_q   <= '0;
      rd_w_q    <= '0;
      rw_w_q    <= 1'b0;
      mis_w_q   <= 1'b0;
    end else if (!stall) begin
      valid_w_q <= valid_m_q;
      res_w_q   <= is_load_m ? ld_m : alu_m_q;
      rd_w_q    <= rd_m_q;
      rw_w_q    <= valid_m_q & rw_m_q & ~(TRAP & mis_m);
      mis_w_q   <= valid_m_q & mis_m;
    end
  end

  assign ALUResult_M = alu_m_q;
  assign Rd_M        = rd_m_q;
  assign RegWrite_M  = valid_m_q & rw_m_q;
  assign out_valid   = valid_w_q;
  assign Result_W    = res_w_q;
  assign Rd_W        = rd_w_q;
  assign RegWrite_W  = rw_w_q;
  assign misalign_W  = mis_w_q;

endmodule

// File: tb/tb_execute_memory_pipe.sv
// Bench for execute_memory_pipe: directed cases plus random traffic
// against a byte-array memory model.
module tb_execute_memory_pipe;

`ifdef EXMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] SrcA, WriteData, ImmExt;
  logic [2:0]  ALUControl;
  logic        ALUSrc, MemWrite, MemRead, MemUnsigned, RegWriteIn;
  logic [1:0]  MemSize;
  logic [4:0]  RdIn;
  logic        zero_E, RegWrite_M, out_valid, RegWrite_W, misalign_W;
  logic [31:0] ALUResult_M, Result_W;
  logic [4:0]  Rd_M, Rd_W;

  always #5 clk = ~clk;

  execute_memory_pipe #(.XLEN(32), .DEPTH(256), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
    .flush(flush), .SrcA(SrcA), .WriteData(WriteData), .ImmExt(ImmExt),
    .ALUControl(ALUControl), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemSize(MemSize), .MemUnsigned(MemUnsigned),
    .RdIn(RdIn), .RegWriteIn(RegWriteIn), .zero_E(zero_E),
    .ALUResult_M(ALUResult_M), .Rd_M(Rd_M), .RegWrite_M(RegWrite_M),
    .out_valid(out_valid), .Result_W(Result_W), .Rd_W(Rd_W),
    .RegWrite_W(RegWrite_W), .misalign_W(misalign_W)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit        v;
    bit [31:0] alu;
    bit [31:0] wd;
    bit        we;
    bit        re;
    bit [1:0]  sz;
    bit        uns;
    bit [4:0]  rd;
    bit        rw;
  } ins_t;

  ins_t             mq;
  bit               wv, wrw, wmis;
  bit [31:0]        wres;
  bit [4:0]         wrd;
  byte unsigned     bmem [1024];

  function automatic bit [31:0] alu_f(bit [2:0] op, bit [31:0] a, bit [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic model_step();
    int        nb, addr, base;
    bit        mis, acc;
    bit [63:0] v;
    bit [31:0] res;
    if (reset) begin
      mq = '{default: 0};
      wv = 0; wres = 0; wrd = 0; wrw = 0; wmis = 0;
    end else begin
      if (!stall) begin
        nb   = (mq.sz == 0) ? 1 : (mq.sz == 1) ? 2 : 4;
        addr = int'(mq.alu[9:0]);
        acc  = mq.we || mq.re;
        mis  = acc && (addr % nb != 0);
        base = addr - addr % nb;
        res  = mq.alu;
        if (mq.we) begin
          if (mq.v && !(TRAP && mis))
            for (int k = 0; k < nb; k++) bmem[base+k] = mq.wd[8*k +: 8];
        end else if (mq.re) begin
          v = 0;
          for (int k = 0; k < nb; k++) v |= 64'(bmem[base+k]) << (8*k);
          if (!mq.uns && v[8*nb-1]) v |= ~((64'd1 << (8*nb)) - 1);
          res = (TRAP && mis) ? 32'd0 : v[31:0];
        end
        wv   = mq.v;
        wres = res;
        wrd  = mq.rd;
        wrw  = mq.v && mq.rw && !(TRAP && mis);
        wmis = mq.v && mis;
      end
      if (flush || !stall) begin
        mq.v   = in_valid && !flush;
        mq.alu = alu_f(ALUControl, SrcA, ALUSrc ? ImmExt : WriteData);
        mq.wd  = WriteData;
        mq.we  = MemWrite;
        mq.re  = MemRead;
        mq.sz  = MemSize;
        mq.uns = MemUnsigned;
        mq.rd  = RdIn;
        mq.rw  = RegWriteIn;
      end
    end
  endtask

  task automatic cycle();
    #1;
    chk("zero_E", zero_E,
        alu_f(ALUControl, SrcA, ALUSrc ? ImmExt : WriteData) == 0);
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", out_valid, wv);
    if (wv) begin
      chk("Result_W", Result_W, wres);
      chk("Rd_W", Rd_W, wrd);
      chk("RegWrite_W", RegWrite_W, wrw);
      chk("misalign_W", misalign_W, wmis);
    end
    chk("RegWrite_M", RegWrite_M, mq.v && mq.rw);
    if (mq.v) begin
      chk("ALUResult_M", ALUResult_M, mq.alu);
      chk("Rd_M", Rd_M, mq.rd);
    end
  endtask

  task automatic drive(bit v, bit [2:0] op, bit [31:0] a, bit [31:0] wd,
                       bit [31:0] imm, bit src, bit we, bit re,
                       bit [1:0] sz, bit uns, bit [4:0] rd, bit rw);
    in_valid = v; ALUControl = op; SrcA = a; WriteData = wd;
    ImmExt = imm; ALUSrc = src; MemWrite = we; MemRead = re;
    MemSize = sz; MemUnsigned = uns; RdIn = rd; RegWriteIn = rw;
  endtask

  task automatic st(bit [31:0] addr, bit [31:0] d, bit [1:0] sz);
    drive(1, 3'd0, addr, d, 32'd0, 1, 1, 0, sz, 0, 5'd0, 0);
    cycle();
  endtask

  task automatic ld(bit [31:0] addr, bit [1:0] sz, bit uns, bit [4:0] rd);
    drive(1, 3'd0, addr, 32'd0, 32'd0, 1, 0, 1, sz, uns, rd, 1);
    cycle();
  endtask

  task automatic alu(bit [2:0] op, bit [31:0] a, bit [31:0] b, bit [4:0] rd);
    drive(1, op, a, b, 32'd0, 0, 0, 0, 2'd2, 0, rd, 1);
    cycle();
  endtask

  task automatic bub();
    drive(0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 2'd0, 0, 5'd0, 0);
    cycle();
  endtask

  initial begin
    bit [31:0] tgt, a;
    int        kind;
    reset = 1; stall = 0; flush = 0;
    drive(0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 2'd0, 0, 5'd0, 0);
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Result_W", Result_W, 0);
    chk("rst_Rd_W", Rd_W, 0);
    chk("rst_RegWrite_W", RegWrite_W, 0);
    chk("rst_misalign_W", misalign_W, 0);
    chk("rst_ALUResult_M", ALUResult_M, 0);
    chk("rst_Rd_M", Rd_M, 0);
    chk("rst_RegWrite_M", RegWrite_M, 0);
    reset = 0;

    for (int w = 0; w < 16; w++) st(32'(w * 4), $urandom, 2'd2);
    bub();

    st(32'h10, 32'hDEADBEEF, 2'd2);
    ld(32'h13, 2'd0, 0, 5'd1);
    bub();
    chk("lb_0x13", Result_W, 32'hFFFFFFDE);
    ld(32'h12, 2'd1, 1, 5'd2);
    bub();
    chk("lhu_0x12", Result_W, 32'h0000DEAD);

    st(32'h20, 32'h11223344, 2'd2);
    st(32'h21, 32'h000000A5, 2'd0);
    ld(32'h20, 2'd2, 0, 5'd3);
    bub();
    chk("lw_merge", Result_W, 32'h1122A544);

    alu(3'd5, 32'h80000000, 32'd1, 5'd4);
    bub();
    chk("slt_neg", Result_W, 32'd1);
    alu(3'd7, 32'h80000000, 32'd1, 5'd4);
    bub();
    chk("srl", Result_W, 32'h40000000);
    alu(3'd1, 32'h80000000, 32'd1, 5'd4);
    bub();
    chk("sub_wrap", Result_W, 32'h7FFFFFFF);
    drive(1, 3'd0, 32'd5, 32'd0, 32'hFFFFFFFB, 1, 0, 0, 2'd2, 0, 5'd5, 1);
    #1 chk("zero_add", zero_E, 1);
    cycle();
    bub();
    chk("add_zero_W", Result_W, 32'd0);

    st(32'h30, 32'hCAFEF00D, 2'd2);
    stall = 1;
    drive(1, 3'd0, 32'd7, 32'd1, 32'd0, 0, 0, 0, 2'd2, 0, 5'd6, 1);
    repeat (3) cycle();
    stall = 0;
    bub();
    ld(32'h30, 2'd2, 0, 5'd8);
    bub();
    chk("stall_store", Result_W, 32'hCAFEF00D);

    stall = 1; flush = 1;
    drive(1, 3'd0, 32'd1, 32'd1, 32'd0, 0, 0, 0, 2'd2, 0, 5'd7, 1);
    cycle();
    stall = 0; flush = 0;
    alu(3'd0, 32'd2, 32'd3, 5'd9);
    chk("flush_gone", out_valid, 0);
    bub();
    chk("flush_next_v", out_valid, 1);
    chk("flush_next_rd", Rd_W, 9);

    ld(32'h22, 2'd2, 0, 5'd10);
    bub();
    chk("mis_flag", misalign_W, 1);
    chk("mis_res", Result_W, TRAP ? 32'd0 : 32'h1122A544);
    chk("mis_rw", RegWrite_W, TRAP ? 1'b0 : 1'b1);
    st(32'h22, 32'hFFFFFFFF, 2'd2);
    ld(32'h20, 2'd2, 0, 5'd11);
    bub();
    chk("mis_store", Result_W, TRAP ? 32'h1122A544 : 32'hFFFFFFFF);

    st(32'h3C, 32'h55AA55AA, 2'd2);
    reset = 1;
    alu(3'd0, 32'd1, 32'd1, 5'd12);
    chk("mid_rst_v", out_valid, 0);
    chk("mid_rst_res", Result_W, 0);
    chk("mid_rst_rwm", RegWrite_M, 0);
    chk("mid_rst_alum", ALUResult_M, 0);
    reset = 0;
    alu(3'd0, 32'd1, 32'd1, 5'd13);
    chk("post_rst_v0", out_valid, 0);
    bub();
    chk("post_rst_v1", out_valid, 1);
    chk("post_rst_res", Result_W, 32'd2);

    for (int n = 0; n < 400; n++) begin
      stall = ($urandom % 8) == 0;
      flush = ($urandom % 10) == 0;
      reset = ($urandom % 60) == 0;
      kind  = $urandom_range(0, 2);
      a     = $urandom;
      tgt   = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
      if (kind == 0)
        drive($urandom % 4 != 0, 3'($urandom), a, $urandom,
              $urandom, 1'($urandom), 0, 0, 2'd2, 0, 5'($urandom),
              1'($urandom));
      else
        drive($urandom % 4 != 0, 3'd0, a, $urandom, tgt - a, 1,
              kind == 2 || ($urandom % 8 == 0), kind == 1,
              2'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      cycle();
    end

    stall = 0; flush = 0; reset = 0;
    bub();
    bub();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_memory_pipe.md
Name: execute_memory_pipe

Overview:
- Parametrised, pipelined execute + data-memory stage for the RISC core.
- Two internal register stages: E→M and M→W.
  - Operand select and ALU in E.
  - Synchronous byte-addressed data memory access in M.
  - Results presented registered to write-back.
- Adds stall/flush control, valid tracking, sub-word loads/stores and configurable width/depth.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- DEPTH, 256, data memory depth in XLEN-bit words; power of two.
- REG_AW, 5, destination register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  E-stage inputs hold a valid instruction
- stall  in  1  freeze both pipeline stages
- flush  in  1  discard the instruction currently presented at E
- SrcA  in  XLEN  ALU operand A
- WriteData  in  XLEN  register operand B / store data
- ImmExt  in  XLEN  extended immediate
- ALUControl  in  3  ALU operation
- ALUSrc  in  1  selects operand B: 0=WriteData, 1=ImmExt
- MemWrite  in  1  store
- MemRead  in  1  load
- MemSize  in  2  access size: 00 byte, 01 half, 10 word, 11 dword
- MemUnsigned  in  1  zero-extend loads
- RdIn  in  REG_AW  destination register
- RegWriteIn  in  1  writes a register
- zero_E  out  1  combinational ALUResult==0, for branch decision
- ALUResult_M  out  XLEN  M-stage registered ALU result, forwarding path
- Rd_M  out  REG_AW  M-stage destination register
- RegWrite_M  out  1  M-stage valid & RegWrite
- out_valid  out  1  W-stage valid
- Result_W  out  XLEN  load data if load, else ALU result
- Rd_W  out  REG_AW  W-stage destination register
- RegWrite_W  out  1  out_valid & RegWrite
- misalign_W  out  1  W-stage instruction made a misaligned access

Behaviour:
- ALU, combinational in E; B = ALUSrc ? ImmExt : WriteData.
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 slt: signed; result 1 or 0, zero-extended.
  - 110 sll; 111 srl: shift amount = B[log2(XLEN)-1:0].
  - Arithmetic wraps modulo 2^XLEN.
- E→M register: captures ALU result, WriteData, control, RdIn and valid = in_valid & ~flush.
  - Updates when ~stall, or when flush=1 regardless of stall (flush loads a bubble with valid=0).
- Memory: DEPTH words of XLEN/8 bytes.
  - Word index = ALUResult_M[log2(DEPTH)+log2(XLEN/8)-1 : log2(XLEN/8)].
  - Upper address bits are ignored: address wraps.
- Store: performed on the clk edge when M valid & MemWrite & ~stall.
  - Byte lanes are selected by size and low address bits; data is the low bytes of WriteData replicated into the selected lanes.
  - Unselected bytes are unchanged.
- Load: synchronous read on the same edge; selected bytes are shifted to bit 0, sign- or zero-extended per MemUnsigned, and registered into W.
- MemSize 11 with XLEN=32: treated as word (10).
- MemRead and MemWrite both set: store wins; W result = ALU result.
- Read and write to the same word on the same edge: read returns the old contents.
- M→W register: updates when ~stall; under stall W holds and out_valid is unchanged.
- Latency: instruction accepted at edge N appears at W after edge N+1. Back-to-back throughput is 1 per cycle.
- Memory contents are not cleared by reset.
- Misalignment: half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0.
  - Base behaviour: the access uses the aligned-down address; misalign_W reports it.
- Reset: at the clk edge with reset=1, all valid bits, ALUResult_M, Rd_M, RegWrite_M, out_valid, Result_W, Rd_W, RegWrite_W and misalign_W become 0. No store is performed during reset.
  - An instruction in flight when reset asserts is discarded.
  - Reset overrides stall and flush.

Optional Feature:
- Macro: EXMEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned store is suppressed: no memory write.
  - A misaligned load returns 0.
  - RegWrite_W is forced to 0 for the trapping instruction.
  - misalign_W=1 with out_valid=1.
- Undefined: aligned-down access as above; misalign_W still reported; RegWrite_W unaffected.

Test Plan:
- Store then load (XLEN=32): word store 0xDEADBEEF at 0x10, then lb at 0x13 unsigned=0 → Result_W=0xFFFFFFDE; lhu at 0x12 → 0x0000DEAD.
- Byte store 0xA5 at 0x21 over word 0x11223344 at 0x20, then lw 0x20 → 0x1122A544.
- ALU sweep: SrcA=0x80000000, B=1.
  - slt → 1; srl → 0x40000000; sub → 0x7FFFFFFF.
  - SrcA=5, Imm=-5, ALUSrc=1, add → zero_E=1, Result_W=0.
- Stall for 3 cycles with a store in M → memory written exactly once after stall drops; W outputs hold for all 3 cycles.
- Flush during stall with a valid instruction at E → that instruction never reaches W (out_valid stays 0 for it); the following instruction proceeds normally.
- Misaligned lw at 0x22: without the macro, reads word 0x20 with misalign_W=1; with EXMEM_MISALIGN_TRAP_EN, Result_W=0, RegWrite_W=0, and a misaligned sw leaves memory unchanged.
- Reset asserted mid-stream: all outputs are 0 on the next edge and out_valid stays 0 until a new in_valid instruction completes 2 cycles later.
